brew_sequencer: RTL and testbench

- Single controller for the coffee machine: takes payment, validates the drink selection against a price table, returns change, and runs the ingredient valves through timed recipe steps.
- Replaces the separate coin-count, compare, subtract, timer and FSM chain with one registered sequencer.
- Sits between the board switches and the valve LEDs / seven-segment drivers. Credit and change feed the existing digit decoders.

---
 rtl/brew_sequencer.sv | 148 ++++++++++++++
 tb/tb_brew_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brew_sequencer.sv
// brew_sequencer: coin/credit handling, price check and timed valve sequencing for the coffee machine.
// Optional SUGAR_OPT_EN adds a no_sugar input that drops the SUGAR step for one brew.
module brew_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int CREDIT_MAX = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_100,
    input  logic [2:0] coffee_type,
    input  logic       confirm,
    input  logic       cancel,
`ifdef SUGAR_OPT_EN
    input  logic       no_sugar,
`endif
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       water,
    output logic       coffee,
    output logic       sugar,
    output logic       milk,
    output logic       chocolate,
    output logic       busy,
    output logic       finished,
    output logic       error
);
    typedef enum logic [2:0] {IDLE, WATER, COFFEE, SUGAR, MILK, CHOC, DONE} state_t;

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

    // Recipe packed as {choc, milk, sugar, coffee, water}, two bits of ticks each.
    function automatic logic [9:0] recipe(input logic [2:0] t);
        case (t)
            3'd0:    recipe = {2'd0, 2'd0, 2'd0, 2'd2, 2'd1};
            3'd1:    recipe = {2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
            3'd2:    recipe = {2'd0, 2'd3, 2'd1, 2'd2, 2'd1};
            3'd3:    recipe = {2'd2, 2'd2, 2'd1, 2'd2, 2'd1};
            3'd4:    recipe = {2'd3, 2'd1, 2'd1, 2'd0, 2'd2};
            default: recipe = 10'd0;
        endcase
    endfunction

    function automatic logic [1:0] price(input logic [2:0] t);
        case (t)
            3'd0, 3'd1: price = 2'd1;
            3'd2, 3'd4: price = 2'd2;
            3'd3:       price = 2'd3;
            default:    price = 2'd0;
        endcase
    endfunction

    // First step at or after index 'from' (0 = water) with nonzero duration, else DONE.
    function automatic state_t first_step(input logic [9:0] r, input logic [2:0] from);
        first_step = DONE;
        for (int i = 4; i >= 0; i--)
            if (i >= int'(from) && r[2*i +: 2] != 2'd0) first_step = state_t'(3'(i + 1));
    endfunction

    function automatic logic [1:0] dur_of(input logic [9:0] r, input state_t s);
        case (s)
            WATER:   dur_of = r[1:0];
            COFFEE:  dur_of = r[3:2];
            SUGAR:   dur_of = r[5:4];
            MILK:    dur_of = r[7:6];
            CHOC:    dur_of = r[9:8];
            default: dur_of = 2'd0;
        endcase
    endfunction

    state_t        state, next_state;
    logic          prev_coin, prev_confirm, prev_cancel;
    logic          coin_e, confirm_e, cancel_e;
    logic [9:0]    rec, rec_in;
    logic [PW-1:0] presc;
    logic [1:0]    tick;
    logic [3:0]    eff;
    logic          accept, reject, do_cancel, restart;

    assign coin_e    = coin_100 & ~prev_coin;
    assign confirm_e = confirm & ~prev_confirm;
    assign cancel_e  = cancel & ~prev_cancel;
    assign eff       = coin_e && credit < CMAX ? credit + 4'd1 : credit;
    assign do_cancel = state == IDLE && cancel_e;
    assign accept    = state == IDLE && confirm_e && !cancel_e && coffee_type < 3'd5 &&
                       eff >= {2'b00, price(coffee_type)};
    assign reject    = state == IDLE && confirm_e && !cancel_e && !accept;
    assign restart   = next_state != state || state == IDLE;

`ifdef SUGAR_OPT_EN
    assign rec_in = recipe(coffee_type) & ~{4'd0, {2{no_sugar}}, 4'd0};
`else
    assign rec_in = recipe(coffee_type);
`endif

    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = accept ? first_step(rec_in, 3'd0) : IDLE;
        else if (state == DONE)
            next_state = presc == PRESC_LAST ? IDLE : DONE;
        else if (presc == PRESC_LAST && tick == dur_of(rec, state) - 2'd1)
            next_state = first_step(rec, 3'(state));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prev_coin    <= 1'b0;
            prev_confirm <= 1'b0;
            prev_cancel  <= 1'b0;
            rec          <= '0;
            presc        <= '0;
            tick         <= '0;
            credit       <= '0;
            change       <= '0;
            error        <= 1'b0;
            water        <= 1'b0;
            coffee       <= 1'b0;
            sugar        <= 1'b0;
            milk         <= 1'b0;
            chocolate    <= 1'b0;
            busy         <= 1'b0;
            finished     <= 1'b0;
        end else begin
            state        <= next_state;
            prev_coin    <= coin_100;
            prev_confirm <= confirm;
            prev_cancel  <= cancel;
            rec          <= accept ? rec_in : rec;
            presc        <= restart || presc == PRESC_LAST ? '0 : presc + PW'(1);
            tick         <= restart ? 2'd0 : presc == PRESC_LAST ? tick + 2'd1 : tick;
            credit       <= accept || do_cancel ? 4'd0 : eff;
            change       <= accept ? eff - {2'b00, price(coffee_type)} :
                            do_cancel ? eff :
                            coin_e && state == IDLE && !reject ? 4'd0 : change;
            error        <= reject ? 1'b1 : coin_e || accept ? 1'b0 : error;
            water        <= next_state == WATER;
            coffee       <= next_state == COFFEE;
            sugar        <= next_state == SUGAR;
            milk         <= next_state == MILK;
            chocolate    <= next_state == CHOC;
            busy         <= next_state != IDLE;
            finished     <= next_state == DONE;
        end
    end
endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: randomized scenario bench for brew_sequencer against a recipe-table model.
module tb_brew_sequencer;
    localparam int TD = 4;

    logic       clock = 1'b0, reset = 1'b0, coin_100 = 1'b0, confirm = 1'b0, cancel = 1'b0;
    logic       no_sugar = 1'b0;
    logic [2:0] coffee_type = 3'd0;
    logic [3:0] credit, change;
    logic       water, coffee, sugar, milk, chocolate, busy, finished, error;

    int checks = 0, errors = 0;
    int m_credit = 0, m_change = 0;
    bit m_error = 1'b0;
    int durs [0:4][0:4] = '{'{1,2,0,0,0}, '{3,2,1,0,0}, '{1,2,1,3,0}, '{1,2,1,2,2}, '{2,0,1,1,3}};
    int prices [0:4] = '{1, 1, 2, 3, 2};

    brew_sequencer #(.TICK_DIV(TD), .CREDIT_MAX(9)) dut (
        .clock(clock), .reset(reset), .coin_100(coin_100), .coffee_type(coffee_type),
        .confirm(confirm), .cancel(cancel),
`ifdef SUGAR_OPT_EN
        .no_sugar(no_sugar),
`endif
        .credit(credit), .change(change), .water(water), .coffee(coffee), .sugar(sugar),
        .milk(milk), .chocolate(chocolate), .busy(busy), .finished(finished), .error(error)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] valves();
        return {chocolate, milk, sugar, coffee, water};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put_coin();
        coin_100 = 1'b1;
        step();
        coin_100 = 1'b0;
        step();
        m_credit = m_credit < 9 ? m_credit + 1 : 9;
        m_error  = 1'b0;
        m_change = 0;
    endtask

    // Pulses confirm and follows the whole brew (or rejection), checking every cycle.
    task automatic run_brew(input int t, input bit ns, input bit prepay);
        int         eff, d;
        bit         ok, ns_eff, fin;
        logic [4:0] exp_v[$];
        eff = m_credit;
        ok = t < 5 && eff >= prices[t];
`ifdef SUGAR_OPT_EN
        ns_eff = ns;
`else
        ns_eff = 1'b0;
`endif
        coffee_type = 3'(t);
        no_sugar = ns;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        coffee_type = 3'($urandom_range(0, 7));
        if (!ok) begin
            m_error = 1'b1;
            for (int i = 0; i < 2 * TD; i++) begin
                checks++;
                if (error !== 1'b1 || credit !== 4'(m_credit) || change !== 4'(m_change) ||
                    busy !== 1'b0 || valves() !== 5'd0) begin
                    errors++;
                    $display("FAIL reject t=%0d cyc=%0d: err=%b cr=%0d ch=%0d busy=%b v=%b, want err=1 cr=%0d ch=%0d busy=0 v=0",
                             t, i, error, credit, change, busy, valves(), m_credit, m_change);
                end
                step();
            end
            return;
        end
        m_change = eff - prices[t];
        m_credit = 0;
        m_error  = 1'b0;
        checks++;
        if (change !== 4'(m_change) || credit !== 4'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL accept t=%0d: ch=%0d cr=%0d err=%b, want ch=%0d cr=0 err=0",
                     t, change, credit, error, m_change);
        end
        for (int s = 0; s < 5; s++) begin
            d = (s == 2 && ns_eff) ? 0 : durs[t][s];
            repeat (d * TD) exp_v.push_back(5'(1 << s));
        end
        repeat (TD) exp_v.push_back(5'd0);
        for (int i = 0; i < exp_v.size(); i++) begin
            if (prepay) coin_100 = (i == 1);
            if (prepay && i == 1) m_credit = 1;
            fin = exp_v[i] == 5'd0;
            checks++;
            if (valves() !== exp_v[i] || busy !== 1'b1 || finished !== fin) begin
                errors++;
                $display("FAIL seq t=%0d ns=%b cyc=%0d: v=%b busy=%b fin=%b, want v=%b busy=1 fin=%b",
                         t, ns_eff, i, valves(), busy, finished, exp_v[i], fin);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || valves() !== 5'd0 ||
            credit !== 4'(m_credit) || change !== 4'(m_change)) begin
            errors++;
            $display("FAIL end t=%0d: busy=%b fin=%b v=%b cr=%0d ch=%0d, want 0 0 0 cr=%0d ch=%0d",
                     t, busy, finished, valves(), credit, change, m_credit, m_change);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({credit, change, valves(), busy, finished, error} !== 16'd0) begin
            errors++;
            $display("FAIL reset: outputs=%h want 0", {credit, change, valves(), busy, finished, error});
        end
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    task automatic test_exact_payment();
        put_coin();
        put_coin();
        checks++;
        if (credit !== 4'd2) begin
            errors++;
            $display("FAIL two_coins: credit=%0d want 2", credit);
        end
        run_brew(2, 1'b0, 1'b0);
    endtask

    task automatic test_change();
        repeat (3) put_coin();
        run_brew(0, 1'b0, 1'b0);
    endtask

    task automatic test_insufficient();
        put_coin();
        run_brew(3, 1'b0, 1'b0);
        put_coin();
        checks++;
        if (error !== 1'b0 || credit !== 4'd2) begin
            errors++;
            $display("FAIL err_clear: err=%b cr=%0d want err=0 cr=2", error, credit);
        end
        put_coin();
        run_brew(3, 1'b0, 1'b0);
    endtask

    task automatic test_saturate_cancel();
        repeat (11) put_coin();
        checks++;
        if (credit !== 4'd9) begin
            errors++;
            $display("FAIL saturate: credit=%0d want 9", credit);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
        checks++;
        if (change !== 4'd9 || credit !== 4'd0) begin
            errors++;
            $display("FAIL cancel: ch=%0d cr=%0d want ch=9 cr=0", change, credit);
        end
        m_change = 9;
        m_credit = 0;
        put_coin();
        checks++;
        if (change !== 4'd0 || credit !== 4'd1) begin
            errors++;
            $display("FAIL coin_after_cancel: ch=%0d cr=%0d want ch=0 cr=1", change, credit);
        end
    endtask

    task automatic test_invalid_and_reset();
        repeat (4) put_coin();
        run_brew(6, 1'b0, 1'b0);
        coffee_type = 3'd2;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        repeat (18) step();
        checks++;
        if (milk !== 1'b1) begin
            errors++;
            $display("FAIL mid_milk: milk=%b want 1", milk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({credit, change, valves(), busy, finished, error} !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h want 0", {credit, change, valves(), busy, finished, error});
        end
        @(negedge clock);
        reset = 1'b0;
        m_credit = 0;
        m_change = 0;
        m_error  = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || valves() !== 5'd0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL after_reset: busy=%b v=%b cr=%0d want 0 0 0", busy, valves(), credit);
        end
    endtask

    task automatic test_prepay();
        put_coin();
        run_brew(1, 1'b0, 1'b1);
        run_brew(0, 1'b0, 1'b0);
    endtask

    task automatic test_sugar_option();
        put_coin();
        run_brew(1, 1'b1, 1'b0);
        no_sugar = 1'b0;
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(0, 4);
            repeat (n) put_coin();
            if ($urandom_range(0, 4) == 0) begin
                cancel = 1'b1;
                step();
                cancel = 1'b0;
                step();
                m_change = m_credit;
                m_credit = 0;
                checks++;
                if (change !== 4'(m_change) || credit !== 4'd0 || error !== m_error) begin
                    errors++;
                    $display("FAIL rnd_cancel k=%0d: ch=%0d cr=%0d err=%b want ch=%0d cr=0 err=%b",
                             k, change, credit, error, m_change, m_error);
                end
            end else begin
                run_brew($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        no_sugar = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exact_payment();
        test_change();
        test_insufficient();
        test_saturate_cancel();
        test_invalid_and_reset();
        test_prepay();
        test_sugar_option();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
